// File: rtl/decrypt_word_packer_if.sv
// Word-side bus of decrypt_word_packer: head-of-FIFO word, byte enables,
// valid/ready handshake and, when WORD_PARITY_EN is defined, per-lane parity.
// The packer drives the master modport; the consumer uses the slave modport.
interface decrypt_word_packer_if;
    logic [31:0] word_out;
    logic [3:0]  keep_out;
    logic        word_valid;
    logic        word_ready;
`ifdef WORD_PARITY_EN
    logic [3:0]  par_out;
`endif

`ifdef WORD_PARITY_EN
    modport master (
        output word_out,
        output keep_out,
        output word_valid,
        output par_out,
        input  word_ready
    );

    modport slave (
        input  word_out,
        input  keep_out,
        input  word_valid,
        input  par_out,
        output word_ready
    );
`else
    modport master (
        output word_out,
        output keep_out,
        output word_valid,
        input  word_ready
    );

    modport slave (
        input  word_out,
        input  keep_out,
        input  word_valid,
        output word_ready
    );
`endif
endinterface

// File: rtl/decrypt_word_packer.sv
// decrypt_word_packer: packs the decryption unit's byte stream into 32-bit
// little-endian words, buffers them in a first-word-fall-through FIFO and
// presents them on a valid/ready bus. The byte source cannot be stalled, so a
// word that finds the FIFO full is dropped and a sticky overflow flag is set.
// Optional build macro: WORD_PARITY_EN adds per-lane even parity (par_out),
// computed when a word is pushed and stored next to it in the FIFO.
module decrypt_word_packer #(
    parameter int FIFO_DEPTH = 8,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            din,
    input  logic                  v,
    input  logic                  flush,
    input  logic                  ovf_clr,
    decrypt_word_packer_if.master bus,
    output logic [LVL_W-1:0]      level,
    output logic                  overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    // Packing state
    logic [31:0] part_q, part_d;
    logic [1:0]  idx_q, idx_d;

    // Word being assembled this cycle and its push request
    logic [31:0] merged;
    logic [2:0]  fill;
    logic        push_req;
    logic [3:0]  push_keep;

    // FIFO storage and control
    logic [31:0]      mem_word_q [FIFO_DEPTH];
    logic [31:0]      mem_word_d [FIFO_DEPTH];
    logic [3:0]       mem_keep_q [FIFO_DEPTH];
    logic [3:0]       mem_keep_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             ovf_q, ovf_d;
    logic             pop;
    logic             push_acc;
    logic             drop;

    // Registered head of FIFO, holds its value while the FIFO is empty
    logic [31:0] out_word_q, out_word_d;
    logic [3:0]  out_keep_q, out_keep_d;

`ifdef WORD_PARITY_EN
    logic [3:0] push_par;
    logic [3:0] mem_par_q [FIFO_DEPTH];
    logic [3:0] mem_par_d [FIFO_DEPTH];
    logic [3:0] out_par_q, out_par_d;
`endif

    // Merge the incoming byte into the partial word and decide whether a word is pushed
    always_comb begin
        merged    = part_q;
        fill      = {1'b0, idx_q};
        push_keep = 4'h0;
        if (v) begin
            case (idx_q)
                2'd0:    merged[7:0]   = din;
                2'd1:    merged[15:8]  = din;
                2'd2:    merged[23:16] = din;
                default: merged[31:24] = din;
            endcase
            fill = {1'b0, idx_q} + 3'd1;
        end
        // A 4th byte always completes a word; flush with that same byte adds nothing
        push_req = (fill == 3'd4) || (flush && (fill != 3'd0));
        case (fill)
            3'd1:    push_keep = 4'b0001;
            3'd2:    push_keep = 4'b0011;
            3'd3:    push_keep = 4'b0111;
            3'd4:    push_keep = 4'b1111;
            default: push_keep = 4'b0000;
        endcase
        part_d = merged;
        idx_d  = fill[1:0];
        if (push_req) begin
            part_d = 32'h0;
            idx_d  = 2'd0;
        end
    end

`ifdef WORD_PARITY_EN
    // Even parity per byte lane of the word being pushed
    always_comb begin
        push_par = {^merged[31:24], ^merged[23:16], ^merged[15:8], ^merged[7:0]};
    end
`endif

    // FIFO bookkeeping: push/pop arbitration, pointers, level, overflow and next head
    always_comb begin
        pop      = (level_q != '0) && bus.word_ready;
        // A full FIFO still takes the word when a pop frees a slot in the same cycle
        push_acc = push_req && ((level_q != LVL_W'(FIFO_DEPTH)) || pop);
        drop     = push_req && !push_acc;

        mem_word_d = mem_word_q;
        mem_keep_d = mem_keep_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;

        if (push_acc) begin
            mem_word_d[wr_ptr_q] = merged;
            mem_keep_d[wr_ptr_q] = push_keep;
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_acc, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        // Set wins over clear when a drop and ovf_clr coincide
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        // The new head is either already in storage or is the word written this cycle
        out_word_d = out_word_q;
        out_keep_d = out_keep_q;
        if (level_d != '0) begin
            if (push_acc && (rd_ptr_d == wr_ptr_q)) begin
                out_word_d = merged;
                out_keep_d = push_keep;
            end else begin
                out_word_d = mem_word_q[rd_ptr_d];
                out_keep_d = mem_keep_q[rd_ptr_d];
            end
        end
    end

`ifdef WORD_PARITY_EN
    // Parity storage and head parity follow the same write/head selection as the word
    always_comb begin
        mem_par_d = mem_par_q;
        if (push_acc) begin
            mem_par_d[wr_ptr_q] = push_par;
        end
        out_par_d = out_par_q;
        if (level_d != '0) begin
            if (push_acc && (rd_ptr_d == wr_ptr_q)) begin
                out_par_d = push_par;
            end else begin
                out_par_d = mem_par_q[rd_ptr_d];
            end
        end
    end
`endif

    // Control and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            part_q     <= 32'h0;
            idx_q      <= 2'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ovf_q      <= 1'b0;
            out_word_q <= 32'h0;
            out_keep_q <= 4'h0;
        end else begin
            part_q     <= part_d;
            idx_q      <= idx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ovf_q      <= ovf_d;
            out_word_q <= out_word_d;
            out_keep_q <= out_keep_d;
        end
    end

    // FIFO storage; contents are only read behind a non-zero level, so no reset
    always_ff @(posedge clk) begin
        mem_word_q <= mem_word_d;
        mem_keep_q <= mem_keep_d;
    end

`ifdef WORD_PARITY_EN
    // Parity storage and registered head parity
    always_ff @(posedge clk) begin
        mem_par_q <= mem_par_d;
        if (rst) begin
            out_par_q <= 4'h0;
        end else begin
            out_par_q <= out_par_d;
        end
    end

    assign bus.par_out = out_par_q;
`endif

    assign bus.word_out   = out_word_q;
    assign bus.keep_out   = out_keep_q;
    assign bus.word_valid = (level_q != '0);
    assign level          = level_q;
    assign overflow       = ovf_q;

endmodule

// File: tb/tb_decrypt_word_packer.sv
// Self-checking bench for decrypt_word_packer: a byte-level reference model
// pushes expected words to a scoreboard queue as stimulus is driven; the head
// of the queue is compared with the DUT every cycle and popped on handshakes.
module tb_decrypt_word_packer;

    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    din = 8'h00;
    logic          v = 1'b0;
    logic          flush = 1'b0;
    logic          ovf_clr = 1'b0;
    logic [LW-1:0] level;
    logic          overflow;

    decrypt_word_packer_if bus ();

    decrypt_word_packer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .v        (v),
        .flush    (flush),
        .ovf_clr  (ovf_clr),
        .bus      (bus),
        .level    (level),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] w;
        logic [3:0]  k;
    } item_t;

    item_t       sb[$];
    item_t       mlast;
    int          midx = 0;
    logic [31:0] mword = 32'h0;
    logic        movf = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] lane_par(input logic [31:0] w);
        return {^w[31:24], ^w[23:16], ^w[15:8], ^w[7:0]};
    endfunction

    // One clock: drive inputs at negedge, check DUT state against the model, advance model
    task automatic cycle(input logic iv, input logic [7:0] id, input logic ifl,
                         input logic ird, input logic iclr);
        logic  pop_now;
        logic  drop;
        int    lvl0;
        item_t it;
        @(negedge clk);
        v = iv; din = id; flush = ifl; bus.word_ready = ird; ovf_clr = iclr;
        #1;
        lvl0 = sb.size();
        chk("level", 32'(level), 32'(lvl0));
        chk("overflow", 32'(overflow), 32'(movf));
        chk("word_valid", 32'(bus.word_valid), 32'(lvl0 != 0));
        if (lvl0 != 0) begin
            chk("word_out", bus.word_out, sb[0].w);
            chk("keep_out", 32'(bus.keep_out), 32'(sb[0].k));
`ifdef WORD_PARITY_EN
            chk("par_out", 32'(bus.par_out), 32'(lane_par(sb[0].w)));
`endif
        end
        pop_now = (lvl0 != 0) && ird;
        if (pop_now) mlast = sb.pop_front();
        drop = 1'b0;
        if (iv) begin
            mword[8*midx +: 8] = id;
            midx++;
        end
        if (midx == 4 || (ifl && midx != 0)) begin
            it.w = mword;
            it.k = 4'((1 << midx) - 1);
            if (lvl0 < DEPTH || pop_now) sb.push_back(it);
            else drop = 1'b1;
            mword = 32'h0;
            midx  = 0;
        end
        if (drop) movf = 1'b1;
        else if (iclr) movf = 1'b0;
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; v = 1'b0; flush = 1'b0; ovf_clr = 1'b0; bus.word_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        midx = 0; mword = 32'h0; movf = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * DEPTH; i++) begin
            if (sb.size() == 0) break;
            cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        end
        chk("drain_done", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b4 [4];
        bus.word_ready = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();

        // Reset values
        chk("rst_word_out", bus.word_out, 32'h0);
        chk("rst_keep_out", 32'(bus.keep_out), 32'h0);
        chk("rst_valid", 32'(bus.word_valid), 32'h0);
        chk("rst_level", 32'(level), 32'h0);
        chk("rst_overflow", 32'(overflow), 32'h0);
`ifdef WORD_PARITY_EN
        chk("rst_par_out", 32'(bus.par_out), 32'h0);
`endif

        // Four bytes form one little-endian word, visible one cycle after the 4th byte
        b4[0] = 8'h11; b4[1] = 8'h22; b4[2] = 8'h33; b4[3] = 8'h44;
        for (int i = 0; i < 4; i++) cycle(1'b1, b4[i], 1'b0, 1'b0, 1'b0);
        #1;
        chk("w1_valid", 32'(bus.word_valid), 32'h1);
        chk("w1_word", bus.word_out, 32'h44332211);
        chk("w1_keep", 32'(bus.keep_out), 32'hF);
        chk("w1_level", 32'(level), 32'd1);

        // Partial word via flush, then flush with nothing pending
        cycle(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hBB, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        #1;
        chk("flush_level", 32'(level), 32'd2);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        #1;
        chk("flush_word", bus.word_out, 32'h0000BBAA);
        chk("flush_keep", 32'(bus.keep_out), 32'h3);
        drain();
        #1;
        chk("empty_hold_word", bus.word_out, 32'h0000BBAA);
        chk("empty_hold_keep", 32'(bus.keep_out), 32'h3);

        // Overflow: 4*DEPTH+4 bytes with no consumer
        for (int i = 0; i < 4 * DEPTH + 4; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        #1;
        chk("ovf_level", 32'(level), 32'(DEPTH));
        chk("ovf_flag", 32'(overflow), 32'h1);
        chk("ovf_head", bus.word_out, 32'h03020100);
        drain();
        #1;
        chk("ovf_last_word", mlast.w, 32'h1F1E1D1C);
        chk("ovf_sticky", 32'(overflow), 32'h1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        #1;
        chk("ovf_cleared", 32'(overflow), 32'h0);

        // Full FIFO with a pop in the cycle of the 4th byte: push accepted
        for (int i = 0; i < 4 * DEPTH + 3; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h63, 1'b0, 1'b1, 1'b0);
        #1;
        chk("full_pop_level", 32'(level), 32'(DEPTH));
        chk("full_pop_ovf", 32'(overflow), 32'h0);
        drain();

        // Fourth byte together with flush: exactly one full word
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h70 + i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hCC, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        #1;
        chk("cc_level", 32'(level), 32'd1);
        chk("cc_word", bus.word_out, 32'hCC727170);
        chk("cc_keep", 32'(bus.keep_out), 32'hF);
        drain();

        // Reset in the middle of traffic: level=3, idx=2
        for (int i = 0; i < 14; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
        #1;
        chk("pre_rst_level", 32'(level), 32'd3);
        do_reset();
        chk("mid_rst_valid", 32'(bus.word_valid), 32'h0);
        chk("mid_rst_level", 32'(level), 32'h0);
        chk("mid_rst_ovf", 32'(overflow), 32'h0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h51 + i), 1'b0, 1'b0, 1'b0);
        #1;
        chk("fresh_word", bus.word_out, 32'h54535251);
        chk("fresh_level", 32'(level), 32'd1);
        drain();

        // Randomised traffic against the scoreboard
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 9) == 0),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0));
        end
        drain();

`ifdef WORD_PARITY_EN
        // Per-lane parity of 32'h01030700 is {1,0,1,0} for lanes 3..0
        b4[0] = 8'h00; b4[1] = 8'h07; b4[2] = 8'h03; b4[3] = 8'h01;
        for (int i = 0; i < 4; i++) cycle(1'b1, b4[i], 1'b0, 1'b0, 1'b0);
        #1;
        chk("par_word", bus.word_out, 32'h01030700);
        chk("par_lanes", 32'(bus.par_out), 32'b1010);
        drain();
`endif

        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
